// File: rtl/array_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | array_pkg : shared types and default sizes for the array scan stage  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEF_N     = 8;
  localparam int DEF_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/scan_cmp_track.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_cmp_track : registered value/index pair, load or keep-better    |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module scan_cmp_track #(
  parameter int WIDTH    = 8,
  parameter int SELW     = 3,
  parameter bit FIND_MAX = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [SELW-1:0]  idx,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] val,
  output logic [SELW-1:0]  val_idx
);

  logic [WIDTH-1:0] val_q, val_d;
  logic [SELW-1:0]  idx_q, idx_d;
  logic             better;

  // Strict comparison so that ties keep the earliest index.
  generate
    if (FIND_MAX) begin : g_max
      assign better = (data > val_q);
    end else begin : g_min
      assign better = (data < val_q);
    end
  endgenerate

  always_comb begin
    val_d = val_q;
    idx_d = idx_q;
    if (clr) begin
      val_d = '0;
      idx_d = '0;
    end else if (en && (load || better)) begin
      val_d = data;
      idx_d = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      idx_q <= '0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

  assign val     = val_q;
  assign val_idx = idx_q;

endmodule
`default_nettype wire

// File: rtl/array_max_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | array_max_scan : walks the operand mux 0..len-1, tracks max (+index) |
// | Option ARRAY_SCAN_MIN_EN adds min_val/min_idx.   Revision : 1.0      |
// +----------------------------------------------------------------------+
module array_max_scan
  import array_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int SELW  = $clog2(N),
  localparam int LENW  = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  output logic [SELW-1:0]  mux_sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [SELW-1:0]  max_idx
`ifdef ARRAY_SCAN_MIN_EN
  ,
  output logic [WIDTH-1:0] min_val,
  output logic [SELW-1:0]  min_idx
`endif
);

  localparam logic [LENW-1:0] N_LEN = LENW'(N);

  scan_state_t     state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [SELW-1:0] mux_sel_q, mux_sel_d;
  logic            accept;
  logic            last_elem;
  logic            scan_en;
  logic            scan_load;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mux_sel_d = mux_sel_q;
    accept    = 1'b0;
    last_elem = (LENW'(mux_sel_q) == (len_q - LENW'(1)));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          len_d     = (len > N_LEN) ? N_LEN : len;
          mux_sel_d = '0;
          state_d   = (len == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (last_elem) begin
          mux_sel_d = '0;
          state_d   = DONE;
        end else begin
          mux_sel_d = mux_sel_q + SELW'(1);
        end
      end
      DONE: begin
        mux_sel_d = '0;
        state_d   = IDLE;
      end
      default: begin
        mux_sel_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      mux_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  assign scan_en   = (state_q == SCAN);
  assign scan_load = (mux_sel_q == '0);
  assign mux_sel   = mux_sel_q;
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);

  // Results clear on an accepted start so a zero-length scan reports 0/0.
  scan_cmp_track #(
    .WIDTH    (WIDTH),
    .SELW     (SELW),
    .FIND_MAX (1'b1)
  ) u_max (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (scan_en),
    .load    (scan_load),
    .idx     (mux_sel_q),
    .data    (mux_data),
    .val     (max_val),
    .val_idx (max_idx)
  );

`ifdef ARRAY_SCAN_MIN_EN
  scan_cmp_track #(
    .WIDTH    (WIDTH),
    .SELW     (SELW),
    .FIND_MAX (1'b0)
  ) u_min (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (scan_en),
    .load    (scan_load),
    .idx     (mux_sel_q),
    .data    (mux_data),
    .val     (min_val),
    .val_idx (min_idx)
  );
`else
  // Only the max tracker is built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_max_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_array_max_scan : directed bench with a schedule-based scan model  |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_array_max_scan;

  localparam int TN = 4;
  localparam int TW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] len = 3'd0;
  logic [1:0] mux_sel;
  logic [7:0] mux_data;
  logic       busy;
  logic       done;
  logic [7:0] max_val;
  logic [1:0] max_idx;
`ifdef ARRAY_SCAN_MIN_EN
  logic [7:0] min_val;
  logic [1:0] min_idx;
`endif

  logic [7:0] mem [TN];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mux_data = mem[mux_sel];

  array_max_scan #(.N(TN), .WIDTH(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .mux_sel  (mux_sel),
    .mux_data (mux_data),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
`ifdef ARRAY_SCAN_MIN_EN
    .min_val  (min_val),
    .min_idx  (min_idx),
`endif
    .max_idx  (max_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan accepted at edge e0 with clamped length L shows busy and
  // mux_sel=d after edge e0+d (d<L), done after edge e0+L, idle afterwards.
  int e = 0;
  int e0 = 0;
  int m_len = 0;
  bit act = 1'b0;
  int p_max, p_maxi, p_min, p_mini;
  int r_max = 0, r_maxi = 0, r_min = 0, r_mini = 0;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      act = 1'b0;
      r_max = 0; r_maxi = 0; r_min = 0; r_mini = 0;
    end else begin
      if ((!act || (e >= e0 + m_len + 2)) && start) begin
        act   = 1'b1;
        e0    = e;
        m_len = (int'(len) > TN) ? TN : int'(len);
        p_max = 0; p_maxi = 0; p_min = 0; p_mini = 0;
        for (int i = 0; i < m_len; i++) begin
          if (i == 0 || int'(mem[i]) > p_max) begin
            p_max = int'(mem[i]); p_maxi = i;
          end
          if (i == 0 || int'(mem[i]) < p_min) begin
            p_min = int'(mem[i]); p_mini = i;
          end
        end
      end
      if (act && (e - e0 == m_len)) begin
        r_max = p_max; r_maxi = p_maxi; r_min = p_min; r_mini = p_mini;
      end
    end
  end

  int  m_d;
  bit  m_busy, m_done;
  int  m_sel;

  always @(negedge clk) begin
    m_d    = e - e0;
    m_busy = act && (m_d < m_len);
    m_done = act && (m_d == m_len);
    m_sel  = m_busy ? m_d : 0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("mux_sel", 32'(mux_sel), m_sel);
    if (!m_busy) begin
      chk("max_val", 32'(max_val), r_max);
      chk("max_idx", 32'(max_idx), r_maxi);
`ifdef ARRAY_SCAN_MIN_EN
      chk("min_val", 32'(min_val), r_min);
      chk("min_idx", 32'(min_idx), r_mini);
`endif
    end
  end

  task automatic set_mem(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
  endtask

  // Pulses start for one cycle and waits (bounded) for done.
  task automatic run_scan(input int l, output int nb, output int pk);
    bit got;
    nb = 0; pk = 0; got = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    len   = l[2:0];
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (busy) nb++;
      if (int'(mux_sel) > pk) pk = int'(mux_sel);
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int nb, pk;

  initial begin
    set_mem(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_max", 32'(max_val), 32'd0);

    // Basic scan
    set_mem(8'h4A, 8'h94, 8'h59, 8'h29);
    run_scan(4, nb, pk);
    chk("basic_max", 32'(max_val), 32'h94);
    chk("basic_idx", 32'(max_idx), 32'd1);
    chk("basic_busy_cycles", nb, 32'd4);
    chk("basic_peak_sel", pk, 32'd3);
    chk("model_basic_max", r_max, 32'h94);

    // Ties keep earliest index; then result hold while array changes
    set_mem(8'd7, 8'd9, 8'd9, 8'd3);
    run_scan(4, nb, pk);
    chk("tie_max", 32'(max_val), 32'd9);
    chk("tie_idx", 32'(max_idx), 32'd1);
    chk("model_tie_idx", r_maxi, 32'd1);
`ifdef ARRAY_SCAN_MIN_EN
    chk("tie_min", 32'(min_val), 32'd3);
    chk("tie_min_idx", 32'(min_idx), 32'd3);
`endif
    @(negedge clk); #1;
    set_mem(8'hFF, 8'h01, 8'hFE, 8'h00);
    repeat (3) @(negedge clk);
    chk("hold_max", 32'(max_val), 32'd9);
    chk("hold_idx", 32'(max_idx), 32'd1);

    // len=0
    run_scan(0, nb, pk);
    chk("len0_max", 32'(max_val), 32'd0);
    chk("len0_busy_cycles", nb, 32'd0);
    chk("len0_peak_sel", pk, 32'd0);

    // len=7 clamps to 4
    set_mem(8'h05, 8'h80, 8'h33, 8'hC1);
    run_scan(7, nb, pk);
    chk("clamp_max", 32'(max_val), 32'hC1);
    chk("clamp_idx", 32'(max_idx), 32'd3);
    chk("clamp_peak_sel", pk, 32'd3);
    chk("clamp_busy_cycles", nb, 32'd4);

    // len=1 reads element 0 only
    set_mem(8'h10, 8'hFF, 8'hFF, 8'hFF);
    run_scan(1, nb, pk);
    chk("len1_max", 32'(max_val), 32'h10);
    chk("len1_idx", 32'(max_idx), 32'd0);

    // start held high through the scan: one scan only
    set_mem(8'h21, 8'h22, 8'hA0, 8'h23);
    @(negedge clk); #1;
    start = 1'b1;
    len   = 3'd4;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) break;
    end
    #1 start = 1'b0;
    chk("held_done", 32'(done), 32'd1);
    chk("held_busy_cycles", nb, 32'd4);
    chk("held_max", 32'(max_val), 32'hA0);
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("held_no_rescan", nb, 32'd0);

    // Reset mid-scan at mux_sel=2
    set_mem(8'h11, 8'h99, 8'h44, 8'h66);
    @(negedge clk); #1;
    start = 1'b1;
    len   = 3'd4;
    @(negedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 10 && mux_sel != 2'd2; i++) @(negedge clk);
    chk("midscan_sel2", 32'(mux_sel), 32'd2);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel", 32'(mux_sel), 32'd0);
    chk("rst_max", 32'(max_val), 32'd0);
    chk("rst_idx", 32'(max_idx), 32'd0);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    run_scan(4, nb, pk);
    chk("post_rst_max", 32'(max_val), 32'h99);
    chk("post_rst_idx", 32'(max_idx), 32'd1);
    chk("post_rst_busy_cycles", nb, 32'd4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_max_scan.md
Name: array_max_scan

Overview:
- Sequencing stage placed directly in front of the N:1 operand mux.
- Drives the mux select through indices 0..len-1, one per clock, and consumes the mux output on the same cycle.
- Tracks the running maximum and its index.
- Used by the find-maximum program and as the inner pass of the sort routine; exposes a start/busy/done handshake to the control unit.

Parameters:
- N, 8: number of array elements on the mux (N >= 2).
- WIDTH, 8: element width in bits.
- SELW, $clog2(N): select width; localparam, not overridable.
- LENW, $clog2(N+1): length-field width; localparam.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- len  input  LENW  number of valid elements; latched when start is accepted.
- mux_sel  output  SELW  select for the downstream mux.
- mux_data  input  WIDTH  mux output; combinational from mux_sel in the same cycle.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- max_val  output  WIDTH  maximum element found.
- max_idx  output  SELW  index of the maximum element.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset (including mid-scan): state=IDLE; mux_sel, busy, done, max_val, max_idx all 0; any scan in flight is abandoned and done is not pulsed.
- States:
  - IDLE: start=1 latches len_q = min(len, N). If len_q==0, go to DONE. Otherwise set mux_sel=0, busy=1, go to SCAN. start=0 stays in IDLE.
  - SCAN: each cycle compares mux_data against max_val. When mux_sel==0, load unconditionally: max_val=mux_data, max_idx=0. Otherwise update only if mux_data > max_val (unsigned, strict). Ties keep the earliest index. If mux_sel==len_q-1, go to DONE and busy drops on the next edge. Otherwise mux_sel increments.
  - DONE: done=1 for exactly one cycle, busy=0, mux_sel returns to 0, then go to IDLE.
- len==0: no elements are read; done pulses one cycle after start; max_val=0, max_idx=0.
- len>N: clamped to N; indices never exceed N-1 and never wrap.
- Latency: start accepted at edge 0, done high during cycle len_q+1 (len_q>=1). Throughput is one scan per len_q+2 cycles.
- start while busy or during DONE: ignored; it is not queued.
- max_val/max_idx:
  - hold the last result from DONE until the next accepted start;
  - update only on the SCAN load/compare rules above;
  - are valid only while done=1 and thereafter while in IDLE.
- mux_sel is registered; mux_data must settle within the same cycle.

Optional Feature:
- ARRAY_SCAN_MIN_EN defined:
  - adds outputs min_val (WIDTH) and min_idx (SELW), reset to 0;
  - tracked with mirrored rules: load at index 0, update on strict <, earliest index wins on ties;
  - valid alongside done.
- Undefined: the ports and logic are absent; the max path is unchanged.

Decomposition:
- Shared package array_pkg holds:
  - FSM state enum scan_state_t {IDLE, SCAN, DONE};
  - default-parameter constants DEF_N=8, DEF_WIDTH=8.
- One natural sub-module, scan_cmp_track, with parameters WIDTH and SELW:
  - registered value/index pair with load/update-on-greater;
  - instantiated once for max, and a second time for min when ARRAY_SCAN_MIN_EN is defined.
  - Its compare direction is selected by a parameter.

Test Plan:
- Basic: N=4, WIDTH=8, array {0x4A,0x94,0x59,0x29} at idx 0..3, len=4, start -> mux_sel 0,1,2,3 on consecutive cycles; done in cycle 5; max_val=0x94, max_idx=1; busy high for 4 cycles.
- Ties: array {7,9,9,3}, len=4 -> max_val=9, max_idx=1 (earliest wins). With ARRAY_SCAN_MIN_EN: min_val=3, min_idx=3.
- Length bounds:
  - len=0 -> done one cycle after start, max_val=0, mux_sel never leaves 0.
  - len=7 with N=4 -> clamped; mux_sel stops at 3.
  - len=1 -> max_idx=0, max_val=element 0.
- Ignored start: start held high for the whole scan -> a single scan only; a new scan begins only on start asserted in IDLE after done.
- Reset mid-scan: assert rst at mux_sel=2 -> next cycle all outputs 0, IDLE, no done. A fresh start then scans correctly from index 0.
- Result hold: after done, change the array contents -> max_val/max_idx unchanged until the next start.
